// File: rtl/statled_rx.sv
// rtl/statled_rx.sv - status LED blink-code decoder (pulse counting, gap framing, confirmation)
module statled_rx #(
  parameter int unsigned BIT_CLKS      = 1000,
  parameter int unsigned GAP_BITS      = 4,
  parameter int unsigned MIN_HIGH_CLKS = 500,
  parameter int unsigned MAX_CODE      = 6,
  parameter int unsigned CONFIRM       = 2,
  parameter bit          LED_ACTIVE    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       led_in,
  output logic [3:0] code,
  output logic       code_stb,
  output logic [3:0] status,
  output logic       status_valid,
  output logic       err
);

  localparam int unsigned GAP_CLKS = GAP_BITS * BIT_CLKS;
  localparam int unsigned RUN_W    = $clog2(GAP_CLKS + 1) + 1;

  localparam logic [RUN_W-1:0] RUN_MAX    = '1;
  localparam logic [RUN_W-1:0] RUN_ONE    = RUN_W'(1);
  localparam logic [RUN_W-1:0] GAP_RUN    = RUN_W'(GAP_CLKS);
  localparam logic [RUN_W-1:0] MIN_RUN    = RUN_W'(MIN_HIGH_CLKS);
  localparam logic [3:0]       CODE_LIMIT = 4'(MAX_CODE + 1);
  localparam logic [3:0]       CONFIRM_N  = 4'(CONFIRM);

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             sync3_q, sync3_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [3:0]       pulse_q, pulse_d;
  logic [3:0]       match_q, match_d;
  logic [3:0]       code_q, code_d;
  logic             code_stb_q, code_stb_d;
  logic [3:0]       status_q, status_d;
  logic             status_valid_q, status_valid_d;
  logic             err_q, err_d;

  logic       on_s, on_prev, rise, fall;
  logic       gap_hit, sync_ok, stuck_hit, pulse_ok, short_high;
  logic       emit;
  logic [3:0] emit_code;
  logic [3:0] pulse_inc;

  // Input conditioning: synchronizer, polarity fold, edges and the level run length
  always_comb begin
    sync1_d = led_in;
    sync2_d = sync1_q;
    sync3_d = sync2_q;
    on_s    = sync2_q ^ ~LED_ACTIVE;
    on_prev = sync3_q ^ ~LED_ACTIVE;
    rise    = on_s & ~on_prev;
    fall    = ~on_s & on_prev;
    if (on_s != on_prev) begin
      run_d = RUN_ONE;
    end else if (run_q == RUN_MAX) begin
      run_d = run_q;
    end else begin
      run_d = run_q + RUN_ONE;
    end
    // run_d counts the current cycle; run_q still holds the length of a run that just ended
    gap_hit    = ~on_s && (run_d == GAP_RUN);
    sync_ok    = ~on_s && (run_d >= GAP_RUN);
    stuck_hit  = on_s && (run_d == GAP_RUN);
    pulse_ok   = fall && (run_q >= MIN_RUN);
    short_high = fall && (run_q < MIN_RUN);
  end

  // Next-state logic for the frame decoder
  always_comb begin
    state_d = state_q;
    case (state_q)
      SYNC: if (sync_ok) state_d = LOW;
      LOW:  if (rise) state_d = HIGH;
      HIGH: begin
        if (fall) begin
          state_d = pulse_ok ? LOW : SYNC;
        end else if (stuck_hit) begin
          state_d = SYNC;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  // Decoder actions: pulse counting, code emission, error reporting and confirmation
  always_comb begin
    pulse_d        = pulse_q;
    match_d        = match_q;
    code_d         = code_q;
    code_stb_d     = 1'b0;
    status_d       = status_q;
    status_valid_d = status_valid_q;
    err_d          = 1'b0;
    emit           = 1'b0;
    emit_code      = 4'd0;
    pulse_inc      = (pulse_q == 4'hf) ? pulse_q : pulse_q + 4'd1;

    case (state_q)
      SYNC: if (sync_ok) pulse_d = 4'd0;
      LOW: begin
        // a rising edge always wins over a gap timeout
        if (!rise && gap_hit && (pulse_q != 4'd0)) begin
          emit      = 1'b1;
          emit_code = pulse_q;
          pulse_d   = 4'd0;
        end
      end
      HIGH: begin
        if (pulse_ok) begin
          if (pulse_inc >= CODE_LIMIT) begin
            // too many pulses for a numbered code: this is the 50/50 default pattern
            emit      = 1'b1;
            emit_code = 4'd0;
            pulse_d   = 4'd0;
          end else begin
            pulse_d = pulse_inc;
          end
        end else if (short_high || (!fall && stuck_hit)) begin
          err_d = 1'b1;
        end
      end
      default: ;
    endcase

    if (err_d) begin
      match_d = 4'd0;
    end

    if (emit) begin
      code_d     = emit_code;
      code_stb_d = 1'b1;
      if (emit_code == code_q) begin
        match_d = (match_q == 4'hf) ? match_q : match_q + 4'd1;
      end else begin
        match_d = 4'd1;
      end
      if (match_d >= CONFIRM_N) begin
        status_d       = emit_code;
        status_valid_d = 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      sync3_q        <= 1'b0;
      run_q          <= '0;
      pulse_q        <= 4'd0;
      match_q        <= 4'd0;
      code_q         <= 4'd0;
      code_stb_q     <= 1'b0;
      status_q       <= 4'd0;
      status_valid_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      sync3_q        <= sync3_d;
      run_q          <= run_d;
      pulse_q        <= pulse_d;
      match_q        <= match_d;
      code_q         <= code_d;
      code_stb_q     <= code_stb_d;
      status_q       <= status_d;
      status_valid_q <= status_valid_d;
      err_q          <= err_d;
    end
  end

  assign code         = code_q;
  assign code_stb     = code_stb_q;
  assign status       = status_q;
  assign status_valid = status_valid_q;
  assign err          = err_q;

endmodule

// File: tb/tb_statled_rx.sv
// tb/tb_statled_rx.sv - self-checking bench for statled_rx
module tb_statled_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       led_in = 1'b1;
  logic [3:0] code;
  logic       code_stb;
  logic [3:0] status;
  logic       status_valid;
  logic       err;

  statled_rx #(
    .BIT_CLKS(8), .GAP_BITS(4), .MIN_HIGH_CLKS(4), .MAX_CODE(6), .CONFIRM(2), .LED_ACTIVE(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .led_in(led_in), .code(code), .code_stb(code_stb),
    .status(status), .status_valid(status_valid), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    bit         is_err;
    logic [3:0] code;
    logic [3:0] st;
    bit         vld;
  } ev_t;

  typedef struct {
    int np; int hl; int ll; int glitch_at;
    int n_stb; int code; int n_err; int st; int vld;
  } vec_t;

  int  n_cmp = 0;
  int  n_fail = 0;
  int  samp = 0;
  int  n_stb = 0;
  int  n_err = 0;
  int  n_both = 0;
  ev_t dut_q[$];
  ev_t exp_q[$];

  // behavioural model state: frame-level view of the blink protocol
  bit  m_sync;
  int  m_pulses, m_last, m_match, m_status;
  bit  m_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic observe();
    ev_t e;
    if (code_stb && err) n_both++;
    if (code_stb) begin
      n_stb++;
      e = '{samp, 1'b0, code, status, status_valid};
      dut_q.push_back(e);
    end
    if (err) begin
      n_err++;
      e = '{samp, 1'b1, 4'd0, status, status_valid};
      dut_q.push_back(e);
    end
  endtask

  // one led_in sample per cycle; outputs are observed at the negedge before driving
  task automatic step(input logic v);
    @(negedge clk);
    observe();
    led_in = v;
    samp++;
  endtask

  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) step(v);
  endtask

  task automatic send_frame(input int np, input int hl, input int ll, input int glitch_at, input int gap);
    for (int p = 1; p <= np; p++) begin
      hold(1'b1, (p == glitch_at) ? 2 : hl);
      hold(1'b0, (p == np) ? gap : ll);
    end
  endtask

  task automatic m_emit(input int idx, input int c);
    ev_t e;
    m_match = (c == m_last) ? ((m_match < 15) ? m_match + 1 : 15) : 1;
    m_last = c;
    if (m_match >= 2) begin
      m_status = c;
      m_valid = 1'b1;
    end
    e = '{idx, 1'b0, 4'(c), 4'(m_status), m_valid};
    exp_q.push_back(e);
  endtask

  task automatic m_error(input int idx);
    ev_t e;
    m_match = 0;
    m_sync = 1'b0;
    e = '{idx, 1'b1, 4'd0, 4'(m_status), m_valid};
    exp_q.push_back(e);
  endtask

  // a condition completed by led sample k is visible at observation k+3
  task automatic seg(input logic level, input int len);
    int s;
    s = samp;
    if (level) begin
      if (m_sync) begin
        if (len >= 32) m_error(s + 31 + 3);
        else if (len < 4) m_error(s + len + 3);
        else begin
          m_pulses++;
          if (m_pulses == 7) begin
            m_emit(s + len + 3, 0);
            m_pulses = 0;
          end
        end
      end
    end else begin
      if (!m_sync) begin
        if (len >= 32) begin
          m_sync = 1'b1;
          m_pulses = 0;
        end
      end else if (len >= 32 && m_pulses > 0) begin
        m_emit(s + 31 + 3, m_pulses);
        m_pulses = 0;
      end
    end
    hold(level, len);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    vec_t vt[12];
    int   b_stb, b_err, s0, np, reps, hl, ll, r, nmin;

    vt[0]  = '{3, 8, 8,  0, 1, 3, 0, 0, 0};
    vt[1]  = '{3, 8, 8,  0, 1, 3, 0, 3, 1};
    vt[2]  = '{5, 8, 8,  2, 0, 3, 1, 3, 1};
    vt[3]  = '{5, 8, 8,  0, 1, 5, 0, 3, 1};
    vt[4]  = '{5, 8, 8,  0, 1, 5, 0, 5, 1};
    vt[5]  = '{7, 8, 8,  0, 1, 0, 0, 5, 1};
    vt[6]  = '{9, 4, 4,  0, 2, 2, 0, 0, 1};
    vt[7]  = '{1, 3, 8,  0, 0, 2, 1, 0, 1};
    vt[8]  = '{6, 4, 8,  0, 1, 6, 0, 0, 1};
    vt[9]  = '{6, 4, 8,  0, 1, 6, 0, 6, 1};
    vt[10] = '{2, 8, 31, 0, 1, 2, 0, 6, 1};
    vt[11] = '{2, 8, 32, 0, 2, 1, 0, 1, 1};

    // reset with the line on: everything cleared
    hold(1'b1, 4);
    check("rst_code", code, 0);
    check("rst_stb", code_stb, 0);
    check("rst_status", status, 0);
    check("rst_valid", status_valid, 0);
    check("rst_err", err, 0);
    @(negedge clk) rst = 1'b0;

    // line held on in SYNC, then a short low run: no decoding yet
    b_stb = n_stb; b_err = n_err;
    hold(1'b1, 40);
    hold(1'b0, 20);
    send_frame(3, 8, 8, 0, 40);
    check("sync_stb", n_stb - b_stb, 0);
    check("sync_err", n_err - b_err, 0);

    // table of frames
    for (int i = 0; i < 12; i++) begin
      b_stb = n_stb; b_err = n_err;
      send_frame(vt[i].np, vt[i].hl, vt[i].ll, vt[i].glitch_at, 40);
      check($sformatf("vec%0d_stb", i), n_stb - b_stb, vt[i].n_stb);
      check($sformatf("vec%0d_err", i), n_err - b_err, vt[i].n_err);
      check($sformatf("vec%0d_code", i), code, vt[i].code);
      check($sformatf("vec%0d_status", i), status, vt[i].st);
      check($sformatf("vec%0d_valid", i), status_valid, vt[i].vld);
    end

    // stuck-on line
    b_stb = n_stb; b_err = n_err; s0 = samp;
    hold(1'b1, 40);
    check("stuck_err", n_err - b_err, 1);
    check("stuck_stb", n_stb - b_stb, 0);
    check("stuck_err_time", (dut_q.size() > 0) ? dut_q[$].idx : -1, s0 + 34);
    hold(1'b0, 8);
    send_frame(2, 8, 8, 0, 40);
    check("stuck_resync_stb", n_stb - b_stb, 0);
    send_frame(3, 8, 8, 0, 40);
    send_frame(3, 8, 8, 0, 40);
    check("stuck_after_stb", n_stb - b_stb, 2);
    check("stuck_after_status", status, 3);
    check("stuck_after_valid", status_valid, 1);

    // reset in the middle of the second pulse
    hold(1'b1, 8);
    hold(1'b0, 8);
    hold(1'b1, 4);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_code", code, 0);
    check("midrst_status", status, 0);
    check("midrst_valid", status_valid, 0);
    check("midrst_stb", code_stb, 0);
    check("midrst_err", err, 0);
    hold(1'b1, 3);
    @(negedge clk) rst = 1'b0;
    b_stb = n_stb;
    hold(1'b1, 1);
    hold(1'b0, 8);
    hold(1'b1, 8);
    hold(1'b0, 40);
    check("midrst_tail_stb", n_stb - b_stb, 0);
    send_frame(3, 8, 8, 0, 40);
    check("midrst_f1_code", code, 3);
    check("midrst_f1_valid", status_valid, 0);
    send_frame(3, 8, 8, 0, 40);
    check("midrst_f2_stb", n_stb - b_stb, 2);
    check("midrst_f2_status", status, 3);
    check("midrst_f2_valid", status_valid, 1);

    // randomized segments against the frame-level model
    led_in = 1'b0;
    @(negedge clk) rst = 1'b1;
    hold(1'b0, 3);
    @(negedge clk) rst = 1'b0;
    dut_q.delete();
    exp_q.delete();
    m_sync = 1'b0; m_pulses = 0; m_last = 0; m_match = 0; m_status = 0; m_valid = 1'b0;
    seg(1'b0, 40);
    for (int f = 0; f < 60; f++) begin
      np = $urandom_range(1, 9);
      reps = $urandom_range(1, 2);
      for (int k = 0; k < reps; k++) begin
        for (int p = 1; p <= np; p++) begin
          r = $urandom_range(0, 19);
          if (r == 0) hl = $urandom_range(1, 3);
          else if (r == 1) hl = $urandom_range(30, 40);
          else hl = $urandom_range(4, 12);
          seg(1'b1, hl);
          if (p == np) ll = $urandom_range(32, 45);
          else if ($urandom_range(0, 9) == 0) ll = $urandom_range(28, 34);
          else ll = $urandom_range(2, 12);
          seg(1'b0, ll);
        end
      end
    end
    seg(1'b0, 50);

    check("rnd_count", dut_q.size(), exp_q.size());
    nmin = (dut_q.size() < exp_q.size()) ? dut_q.size() : exp_q.size();
    for (int i = 0; i < nmin; i++) begin
      check($sformatf("rnd_ev%0d_time", i), dut_q[i].idx, exp_q[i].idx);
      check($sformatf("rnd_ev%0d_data", i),
            {dut_q[i].is_err, dut_q[i].code, dut_q[i].st, dut_q[i].vld},
            {exp_q[i].is_err, exp_q[i].code, exp_q[i].st, exp_q[i].vld});
    end
    check("rnd_final_status", status, m_status);
    check("rnd_final_valid", status_valid, m_valid);
    check("stb_err_together", n_both, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
